mux_scanner: RTL and testbench
==============================

MUX_SCANNER -- requirements
Module: mux_scanner

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 1, giving the number of settle cycles after each mux_sel change before sampling (legal range 1..15).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: request one 8-channel scan.
REQ-005 The block SHALL have port mux_dout, input, 1 bit: selected bit returned by the downstream 8:1 mux.
REQ-006 The block SHALL have port mux_sel, output, 3 bits: channel select driven to the 8:1 mux.
REQ-007 The block SHALL have port busy, output, 1 bit: high while a scan is in progress (states SETTLE, SAMPLE).
REQ-008 The block SHALL have port data_out, output, 8 bits: assembled word; bit k is the value sampled from channel k.
REQ-009 The block SHALL have port data_valid, output, 1 bit: data_out holds a completed word.
REQ-010 The block SHALL have port data_ready, input, 1 bit: consumer accepts data_out when high together with data_valid.

Function
REQ-011 The block SHALL implement the states IDLE, SETTLE, SAMPLE and HOLD.
REQ-012 In IDLE with start=1, the block SHALL set mux_sel=0, load the settle counter with SETTLE_CYCLES, clear the shadow word and go to SETTLE.
REQ-013 In IDLE with start=0, the block SHALL stay in IDLE with mux_sel=0.
REQ-014 SETTLE SHALL decrement the counter each cycle and go to SAMPLE on the edge where the counter reaches 1.
REQ-015 SETTLE SHALL therefore last exactly SETTLE_CYCLES cycles.
REQ-016 SAMPLE SHALL last 1 cycle; at its closing edge, mux_dout SHALL be written to shadow bit [mux_sel].
REQ-017 In SAMPLE with mux_sel<7, the block SHALL increment mux_sel, reload the counter and return to SETTLE.
REQ-018 In SAMPLE with mux_sel=7, the block SHALL copy the shadow word, with bit 7 included, into data_out, set data_valid=1, set mux_sel=0 and go to HOLD.
REQ-019 Latency: for a start accepted at edge E0, data_valid SHALL first be high after edge E0 + 8*(SETTLE_CYCLES+1).
REQ-020 Latency example: with SETTLE_CYCLES=1, data_valid SHALL first be high after 16 cycles.
REQ-021 mux_sel SHALL change only on state-transition edges and never during SETTLE.
REQ-022 mux_sel SHALL not exceed 7 or wrap within a scan.
REQ-023 In HOLD, data_out and data_valid SHALL remain stable until data_valid & data_ready.
REQ-024 On the edge where data_valid & data_ready, the block SHALL clear data_valid and go to IDLE; data_out keeps its value.
REQ-025 start SHALL be ignored in SETTLE, SAMPLE and HOLD (no queuing).
REQ-026 A start pulse arriving during HOLD SHALL have no effect even if data_ready is high in the same cycle.
REQ-027 data_ready SHALL be ignored when data_valid=0.
REQ-028 busy SHALL be a registered state decode, 1 exactly in SETTLE and SAMPLE.
REQ-029 Behaviour with an illegal SETTLE_CYCLES value (0 or greater than 15) SHALL be undefined; the bench SHALL not use such values.

Reset
REQ-030 When rst_n=0 at a rising edge, the block SHALL go to IDLE and set mux_sel=0, busy=0, data_valid=0, data_out=8'h00, the shadow word to 0 and the counter to 0.
REQ-031 Reset asserted mid-scan or in HOLD SHALL discard the partial or held word; there SHALL be no handshake completion on that edge.
REQ-032 start SHALL be honoured on the first edge with rst_n=1.

Verification
REQ-033 Basic scan: SETTLE_CYCLES=1, mux din=8'hA5, pulse start, data_ready=1 -> mux_sel steps 0..7 every 2 cycles; data_valid high after 16 cycles; data_out=8'hA5; busy high for exactly 16 cycles.
REQ-034 Backpressure: din=8'h3C, data_ready=0 for 10 cycles after valid, then 1 -> data_out stays 8'h3C and data_valid stays high for 10 cycles; one transfer, then IDLE.
REQ-035 Settle timing: SETTLE_CYCLES=3, din=8'h81 -> each mux_sel value held 4 cycles; data_valid after 32 cycles; data_out=8'h81.
REQ-036 Ignored start: start held high throughout the scan and HOLD, din=8'hFF -> exactly one word 8'hFF per IDLE entry; no restart until IDLE.
REQ-037 Mid-scan reset: rst_n=0 while mux_sel=4 -> next edge gives mux_sel=0, busy=0, data_valid=0, data_out=8'h00; a new start then yields the full word.
REQ-038 Back-to-back: din changes from 8'h0F to 8'hF0 between scans, with start issued in the first IDLE cycle -> words 8'h0F then 8'hF0, with no corruption from the earlier shadow word.

Source files
------------

// File: rtl/mux_scanner.sv
// Scans an external 8:1 mux one channel at a time, waiting a fixed number of
// settle cycles before each sample, and presents the assembled byte with a valid/ready handshake.
module mux_scanner #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       mux_dout,
  output logic [2:0] mux_sel,
  output logic       busy,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       data_ready
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [2:0] mux_sel_nxt;
  logic [7:0] shadow, shadow_nxt;
  logic [7:0] data_out_nxt;
  logic       data_valid_nxt;
  logic       busy_nxt;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned; that is what keeps this process free of inferred latches.
    state_nxt      = state;
    cnt_nxt        = cnt;
    mux_sel_nxt    = mux_sel;
    shadow_nxt     = shadow;
    data_out_nxt   = data_out;
    data_valid_nxt = data_valid;

    case (state)
      IDLE: begin
        mux_sel_nxt = 3'd0;
        if (start) begin
          cnt_nxt    = SETTLE_LOAD;
          shadow_nxt = 8'h00;
          state_nxt  = SETTLE;
        end
      end

      SETTLE: begin
        // Leaving on the edge that sees 1 makes SETTLE last exactly SETTLE_CYCLES.
        cnt_nxt = cnt - 4'd1;
        if (cnt <= 4'd1) begin
          state_nxt = SAMPLE;
        end
      end

      SAMPLE: begin
        shadow_nxt[mux_sel] = mux_dout;
        if (mux_sel == 3'd7) begin
          // Bit 7 is taken straight from the mux; the shadow copy is not yet updated.
          data_out_nxt   = {mux_dout, shadow[6:0]};
          data_valid_nxt = 1'b1;
          mux_sel_nxt    = 3'd0;
          state_nxt      = HOLD;
        end else begin
          mux_sel_nxt = mux_sel + 3'd1;
          cnt_nxt     = SETTLE_LOAD;
          state_nxt   = SETTLE;
        end
      end

      HOLD: begin
        if (data_valid && data_ready) begin
          data_valid_nxt = 1'b0;
          state_nxt      = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    busy_nxt = (state_nxt == SETTLE) || (state_nxt == SAMPLE);
  end

  always_ff @(posedge clk) begin
    // NOTE: the reset also clears the shadow word; it is a plain register,
    // and a cleared value keeps a discarded partial scan from leaking out.
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      mux_sel    <= 3'd0;
      shadow     <= 8'h00;
      data_out   <= 8'h00;
      data_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every register samples pre-edge values.
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      mux_sel    <= mux_sel_nxt;
      shadow     <= shadow_nxt;
      data_out   <= data_out_nxt;
      data_valid <= data_valid_nxt;
      busy       <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_mux_scanner.sv
// Bench for mux_scanner: two instances (SETTLE_CYCLES 1 and 3) driven from one
// stimulus stream; expectations come from the scan timing arithmetic and the mux input word.
module tb_mux_scanner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       data_ready;
  logic       use3;
  logic [7:0] din;

  logic       start1, start3, md1, md3;
  logic [2:0] sel1, sel3;
  logic       busy1, busy3, dv1, dv3;
  logic [7:0] do1, do3;

  logic [2:0] o_sel;
  logic       o_busy, o_valid;
  logic [7:0] o_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign start1 = start & ~use3;
  assign start3 = start & use3;
  assign md1    = din[sel1];
  assign md3    = din[sel3];

  assign o_sel   = use3 ? sel3  : sel1;
  assign o_busy  = use3 ? busy3 : busy1;
  assign o_valid = use3 ? dv3   : dv1;
  assign o_data  = use3 ? do3   : do1;

  mux_scanner #(.SETTLE_CYCLES(1)) dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start1),
    .mux_dout   (md1),
    .mux_sel    (sel1),
    .busy       (busy1),
    .data_out   (do1),
    .data_valid (dv1),
    .data_ready (data_ready)
  );

  mux_scanner #(.SETTLE_CYCLES(3)) dut3 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start3),
    .mux_dout   (md3),
    .mux_sel    (sel3),
    .busy       (busy3),
    .data_out   (do3),
    .data_valid (dv3),
    .data_ready (data_ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full scan of 'word' followed by a handshake after 'ready_delay' stalled HOLD cycles.
  task automatic scan(input logic [7:0] word, input int ready_delay, input bit hold_start);
    int s;
    int lat;
    s   = use3 ? 3 : 1;
    lat = 8 * (s + 1);
    din        = word;
    start      = 1'b1;
    data_ready = (ready_delay == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    tick();
    if (!hold_start) start = 1'b0;
    for (int k = 0; k < lat; k++) begin
      check("scan_sel",   32'(o_sel),   32'(k / (s + 1)));
      check("scan_busy",  32'(o_busy),  32'd1);
      check("scan_valid", 32'(o_valid), 32'd0);
      tick();
    end
    check("done_valid", 32'(o_valid), 32'd1);
    check("done_data",  32'(o_data),  32'(word));
    check("done_busy",  32'(o_busy),  32'd0);
    check("done_sel",   32'(o_sel),   32'd0);
    din = 8'($urandom);
    if (ready_delay > 0) data_ready = 1'b0;
    for (int i = 0; i < ready_delay; i++) begin
      tick();
      check("hold_valid", 32'(o_valid), 32'd1);
      check("hold_data",  32'(o_data),  32'(word));
      check("hold_busy",  32'(o_busy),  32'd0);
    end
    data_ready = 1'b1;
    tick();
    check("xfer_valid", 32'(o_valid), 32'd0);
    check("xfer_data",  32'(o_data),  32'(word));
    check("xfer_busy",  32'(o_busy),  32'd0);
    data_ready = 1'b0;
    start      = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b1;
    data_ready = 1'b0;
    din        = 8'h00;
    use3       = 1'b0;
    tick();
    tick();
    check("rst_sel1",   32'(sel1),  32'd0);
    check("rst_busy1",  32'(busy1), 32'd0);
    check("rst_valid1", 32'(dv1),   32'd0);
    check("rst_data1",  32'(do1),   32'd0);
    check("rst_sel3",   32'(sel3),  32'd0);
    check("rst_busy3",  32'(busy3), 32'd0);
    check("rst_valid3", 32'(dv3),   32'd0);
    check("rst_data3",  32'(do3),   32'd0);

    // Start honoured on the first edge out of reset.
    rst_n = 1'b1;
    scan(8'hA5, 0, 1'b0);
    scan(8'h3C, 10, 1'b0);
    scan(8'hFF, 2, 1'b1);

    // Back-to-back: second start lands in the first IDLE cycle.
    scan(8'h0F, 0, 1'b0);
    scan(8'hF0, 0, 1'b0);

    // Reset while mux_sel = 4.
    din   = 8'h96;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (8) tick();
    check("mid_sel4", 32'(o_sel),  32'd4);
    check("mid_busy", 32'(o_busy), 32'd1);
    rst_n      = 1'b0;
    data_ready = 1'b1;
    tick();
    check("mid_rst_sel",   32'(o_sel),   32'd0);
    check("mid_rst_busy",  32'(o_busy),  32'd0);
    check("mid_rst_valid", 32'(o_valid), 32'd0);
    check("mid_rst_data",  32'(o_data),  32'd0);
    rst_n      = 1'b1;
    data_ready = 1'b0;
    scan(8'h5A, 1, 1'b0);

    // Reset while holding a word, with data_ready high on that edge.
    din   = 8'hC3;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (16) tick();
    check("hrst_pre_valid", 32'(o_valid), 32'd1);
    check("hrst_pre_data",  32'(o_data),  32'hC3);
    rst_n      = 1'b0;
    data_ready = 1'b1;
    tick();
    check("hrst_valid", 32'(o_valid), 32'd0);
    check("hrst_data",  32'(o_data),  32'd0);
    check("hrst_busy",  32'(o_busy),  32'd0);
    rst_n      = 1'b1;
    data_ready = 1'b0;

    for (int r = 0; r < 6; r++) begin
      scan(8'($urandom), int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)));
    end

    // Longer settle time on the second instance.
    use3 = 1'b1;
    scan(8'h81, 0, 1'b0);
    for (int r = 0; r < 2; r++) begin
      scan(8'($urandom), int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
